// File: rtl/coin_pkg.sv
// Shared types and constants for the coin transfer pipeline.
package coin_pkg;

    // Default widths for the player-memory slice.
    localparam int DEF_ADDR_W = 2;
    localparam int DEF_BAL_W  = 12;
    localparam int DEF_AMT_W  = 8;

    // Transfer sequencer states; the encoding is visible on the debug port.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RD_SEND = 3'd2,
        VERIFY  = 3'd3,
        CHECK   = 3'd4,
        WR_SEND = 3'd5,
        WR_RECV = 3'd6,
        DONE    = 3'd7
    } state_t;

    // Result codes reported on status.
    localparam logic [2:0] ST_OK          = 3'd0;
    localparam logic [2:0] ST_VERIFY_FAIL = 3'd1;
    localparam logic [2:0] ST_FUNDS       = 3'd2;
    localparam logic [2:0] ST_OVERFLOW    = 3'd3;
    localparam logic [2:0] ST_SELF        = 3'd4;
    localparam logic [2:0] ST_ZERO        = 3'd5;
    localparam logic [2:0] ST_TIMEOUT     = 3'd6;

endpackage

// File: rtl/balance_alu.sv
// Combinational debit/credit arithmetic and the two commit guards.
// Unsigned throughout; the sum is one bit wider so a carry means overflow.
module balance_alu
    import coin_pkg::*;
#(
    parameter int BAL_W = DEF_BAL_W,
    parameter int AMT_W = DEF_AMT_W
) (
    input  logic [BAL_W-1:0] send_bal,
    input  logic [BAL_W-1:0] recv_bal,
    input  logic [AMT_W-1:0] amount,
    output logic [BAL_W-1:0] debit,
    output logic [BAL_W-1:0] credit,
    output logic             funds_fail,
    output logic             overflow
);

    logic [BAL_W-1:0] amt_ext;
    logic [BAL_W:0]   sum;

    // Zero-extend the amount and derive both results and both guards.
    always_comb begin
        amt_ext    = BAL_W'(amount);
        sum        = {1'b0, recv_bal} + {1'b0, amt_ext};
        debit      = send_bal - amt_ext;
        credit     = sum[BAL_W-1:0];
        funds_fail = (send_bal < amt_ext);
        overflow   = sum[BAL_W];
    end

endmodule

// File: rtl/transfer_control.sv
// Sequencer for one coin transfer: load the verify stage, read both
// balances, wait for a verdict, then commit debit and credit.
// Handshake: verify_valid is a one-cycle qualifier; verify_pass is only
// looked at when verify_valid=1, and only while the FSM is in VERIFY.
// start is a level sampled in IDLE only; it is dropped (not queued) when busy.
// A reset landing between WR_SEND and WR_RECV leaves a debit without its
// credit; this is accepted behaviour.
module transfer_control
    import coin_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int BAL_W   = DEF_BAL_W,
    parameter int AMT_W   = DEF_AMT_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] sender,
    input  logic [ADDR_W-1:0] receiver,
    input  logic [AMT_W-1:0]  amount_in,
    input  logic [AMT_W-1:0]  key_in,
    output logic              load_amount,
    output logic              load_key,
    input  logic              verify_valid,
    input  logic              verify_pass,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [BAL_W-1:0]  mem_rdata,
    output logic              mem_we,
    output logic [BAL_W-1:0]  mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [2:0]        status,
    output logic [2:0]        state_dbg
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            state, state_d;
    logic [ADDR_W-1:0] snd_q, rcv_q;
    logic [AMT_W-1:0]  amt_q;
    logic [BAL_W-1:0]  send_bal_q, recv_bal_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        status_q, status_d;
    logic [BAL_W-1:0]  debit, credit;
    logic              funds_fail, overflow;

    // The key goes straight from the shared bus to the verify stage.
    logic unused_key;
    assign unused_key = ^key_in;

    balance_alu #(
        .BAL_W (BAL_W),
        .AMT_W (AMT_W)
    ) u_alu (
        .send_bal   (send_bal_q),
        .recv_bal   (recv_bal_q),
        .amount     (amt_q),
        .debit      (debit),
        .credit     (credit),
        .funds_fail (funds_fail),
        .overflow   (overflow)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (!resetn) state <= IDLE;
        else         state <= state_d;
    end

    // Next state and the result code that goes with entering DONE.
    always_comb begin
        state_d  = state;
        status_d = status_q;
        case (state)
            IDLE: begin
                if (start) begin
                    if (sender == receiver) begin
                        state_d  = DONE;
                        status_d = ST_SELF;
                    end else if (amount_in == '0) begin
                        state_d  = DONE;
                        status_d = ST_ZERO;
                    end else begin
                        state_d  = LOAD;
                        status_d = ST_OK;
                    end
                end
            end
            LOAD:    state_d = RD_SEND;
            RD_SEND: state_d = VERIFY;
            VERIFY: begin
                if (verify_valid) begin
                    if (verify_pass) begin
                        state_d = CHECK;
                    end else begin
                        state_d  = DONE;
                        status_d = ST_VERIFY_FAIL;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d  = DONE;
                    status_d = ST_TIMEOUT;
                end
            end
            CHECK: begin
                if (funds_fail) begin
                    state_d  = DONE;
                    status_d = ST_FUNDS;
                end else if (overflow) begin
                    state_d  = DONE;
                    status_d = ST_OVERFLOW;
                end else begin
                    state_d = WR_SEND;
                end
            end
            WR_SEND: state_d = WR_RECV;
            WR_RECV: begin
                state_d  = DONE;
                status_d = ST_OK;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, balance capture, verdict timer and held status.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            snd_q      <= '0;
            rcv_q      <= '0;
            amt_q      <= '0;
            send_bal_q <= '0;
            recv_bal_q <= '0;
            cnt_q      <= '0;
            status_q   <= ST_OK;
        end else begin
            if (state == IDLE && start) begin
                snd_q <= sender;
                rcv_q <= receiver;
                amt_q <= amount_in;
            end
            if (state == RD_SEND) recv_bal_q <= mem_rdata;
            if (state == VERIFY)  send_bal_q <= mem_rdata;
            cnt_q    <= (state == VERIFY) ? cnt_q + 1'b1 : '0;
            status_q <= status_d;
        end
    end

    // Moore outputs; the write enable is gated by reset in the same cycle.
    always_comb begin
        busy        = (state != IDLE);
        done        = (state == DONE);
        load_amount = (state == LOAD);
        load_key    = (state == LOAD);
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (state)
            LOAD:    mem_addr = rcv_q;
            RD_SEND: mem_addr = snd_q;
            VERIFY:  mem_addr = snd_q;
            WR_SEND: begin
                mem_we    = resetn;
                mem_addr  = snd_q;
                mem_wdata = debit;
            end
            WR_RECV: begin
                mem_we    = resetn;
                mem_addr  = rcv_q;
                mem_wdata = credit;
            end
            default: ;
        endcase
        status    = status_q;
        state_dbg = state;
    end

endmodule

// File: tb/tb_transfer_control.sv
// Bench for transfer_control: constant vector table, hand-written reset
// sequences and a randomized run scored against a transfer-level model.
`timescale 1ns/1ps
module tb_transfer_control;

  localparam int AW     = 2;
  localparam int BW     = 12;
  localparam int XW     = 8;
  localparam int TO     = 255;
  localparam int BUDGET = 400;
  localparam int MAXBAL = 4095;

  // ---------------- clock / reset / DUT ----------------
  logic          clock;
  logic          resetn;
  logic          start;
  logic [AW-1:0] sender, receiver;
  logic [XW-1:0] amount_in, key_in;
  logic          load_amount, load_key;
  logic          verify_valid, verify_pass;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_rdata;
  logic          mem_we;
  logic [BW-1:0] mem_wdata;
  logic          busy, done;
  logic [2:0]    status;
  logic [2:0]    state_dbg;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  transfer_control #(
    .ADDR_W (AW), .BAL_W (BW), .AMT_W (XW), .TIMEOUT (TO)
  ) dut (
    .clock (clock), .resetn (resetn), .start (start),
    .sender (sender), .receiver (receiver),
    .amount_in (amount_in), .key_in (key_in),
    .load_amount (load_amount), .load_key (load_key),
    .verify_valid (verify_valid), .verify_pass (verify_pass),
    .mem_addr (mem_addr), .mem_rdata (mem_rdata),
    .mem_we (mem_we), .mem_wdata (mem_wdata),
    .busy (busy), .done (done), .status (status), .state_dbg (state_dbg)
  );

  // Player memory: 1-cycle read latency, bench-side preload port.
  logic [BW-1:0] mem [4];
  logic          tb_we;
  logic [AW-1:0] tb_waddr;
  logic [BW-1:0] tb_wdata;

  always @(posedge clock) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we)     mem[mem_addr] <= mem_wdata;
    else if (tb_we) mem[tb_waddr] <= tb_wdata;
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [AW+BW-1:0] exp_q[$];
  int model_mem [4];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_wr(input int a, input int v);
    exp_q.push_back({AW'(a), BW'(v)});
  endtask

  // Transfer-level reference: result code, done cycle, expected writes.
  task automatic model_xfer(input int s, input int r, input int amt, input int vc,
                            input bit pass, output int st, output int dc);
    int last_verify;
    last_verify = 2 + TO;
    if (s == r) begin
      st = 4; dc = 1;
    end else if (amt == 0) begin
      st = 5; dc = 1;
    end else if (vc < 3 || vc > last_verify) begin
      st = 6; dc = last_verify + 1;
    end else if (!pass) begin
      st = 1; dc = vc + 1;
    end else if (model_mem[s] < amt) begin
      st = 2; dc = vc + 2;
    end else if (model_mem[r] + amt > MAXBAL) begin
      st = 3; dc = vc + 2;
    end else begin
      st = 0; dc = vc + 4;
      push_wr(s, model_mem[s] - amt);
      push_wr(r, model_mem[r] + amt);
      model_mem[s] = model_mem[s] - amt;
      model_mem[r] = model_mem[r] + amt;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_bal(input int a, input int v);
    tb_we = 1'b1; tb_waddr = AW'(a); tb_wdata = BW'(v);
    model_mem[a] = v;
    @(posedge clock); #1;
    tb_we = 1'b0;
  endtask

  // Issue one start from IDLE; verdict in cycle vc (0 = never). Returns
  // status and cycle of done; ends in the IDLE cycle after done.
  task automatic xfer(input int s, input int r, input int amt, input int vc,
                      input bit pass, input int pulses, input int exp_st,
                      output int st, output int dc);
    int c, load_cnt, key_cnt, load_c, busy_bad, early;
    bit seen;
    logic [AW+BW-1:0] e;
    load_cnt = 0; key_cnt = 0; load_c = 0; busy_bad = 0; seen = 0;
    st = -1; dc = -1;
    early = (s == r || amt == 0) ? 1 : 0;
    sender = AW'(s); receiver = AW'(r); amount_in = XW'(amt);
    key_in = XW'($urandom_range(0, 255)); start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    c = 1;
    while (c <= BUDGET) begin
      if (!busy) busy_bad++;
      if (load_amount) begin
        load_cnt++;
        if (load_c == 0) load_c = c;
      end
      if (load_key) key_cnt++;
      if (mem_we) begin
        if (exp_q.size() == 0) check("unexp_write", int'(mem_we), 0);
        else begin
          e = exp_q.pop_front();
          check("wr_addr", int'(mem_addr), int'(e[BW+:AW]));
          check("wr_data", int'(mem_wdata), int'(e[BW-1:0]));
        end
      end
      if (done) begin
        seen = 1; st = int'(status); dc = c;
      end
      verify_valid = (c == vc); verify_pass = pass;
      if (!done && c >= 2 && c < 2 + pulses) begin
        start = 1'b1;
        sender = AW'($urandom_range(0, 3)); receiver = AW'($urandom_range(0, 3));
        amount_in = XW'($urandom_range(0, 255));
      end else begin
        start = 1'b0;
      end
      if (done) break;
      @(posedge clock); #1;
      c++;
    end
    check("done_seen", int'(seen), 1);
    verify_valid = 1'b0; start = 1'b0;
    check("load_amount_cnt", load_cnt, early ? 0 : 1);
    check("load_key_cnt", key_cnt, early ? 0 : 1);
    check("load_cycle", load_c, early ? 0 : 1);
    check("busy_during", busy_bad, 0);
    check("writes_left", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clock); #1;
    check("idle_busy", int'(busy), 0);
    check("idle_done", int'(done), 0);
    check("status_held", int'(status), exp_st);
  endtask

  // Start a nominal transfer (pass in c3) and stop in cycle upto.
  task automatic run_until(input int s, input int r, input int amt, input int upto);
    sender = AW'(s); receiver = AW'(r); amount_in = XW'(amt); start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int c = 1; c < upto; c++) begin
      verify_valid = (c == 3); verify_pass = 1'b1;
      @(posedge clock); #1;
    end
    verify_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_mem_we"}, int'(mem_we), 0);
    check({tag, "_load_amount"}, int'(load_amount), 0);
    check({tag, "_load_key"}, int'(load_key), 0);
    check({tag, "_status"}, int'(status), 0);
    check({tag, "_mem_addr"}, int'(mem_addr), 0);
    check({tag, "_mem_wdata"}, int'(mem_wdata), 0);
    check({tag, "_state"}, int'(state_dbg), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int s; int r; int amt; int vc; int pass; int pulses;
    int bal_s; int bal_r;
    int exp_st; int exp_dc; int exp_s; int exp_r;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int st, dc, est, edc, s, r, amt, vc;
    bit pass;

    //            s  r amt  vc  p pul bal_s bal_r  st  dc  exp_s exp_r
    vecs[0]  = '{0, 1, 30,   3, 1, 0,  100,   50,  0,  7,   70,   80};
    vecs[1]  = '{0, 1, 30,   3, 0, 0,  100,   50,  1,  4,  100,   50};
    vecs[2]  = '{0, 1, 10,   3, 1, 0,  100, 4090,  3,  5,  100, 4090};
    vecs[3]  = '{2, 3,  6,   3, 1, 0,    5,   20,  2,  5,    5,   20};
    vecs[4]  = '{2, 2, 10,   3, 1, 0,   40,   40,  4,  1,   40,   40};
    vecs[5]  = '{1, 3,  0,   3, 1, 0,   60,   70,  5,  1,   60,   70};
    vecs[6]  = '{2, 2,  0,   3, 1, 0,   40,   40,  4,  1,   40,   40};
    vecs[7]  = '{1, 0,  5,   0, 1, 6,  200,  100,  6, 258, 200,  100};
    vecs[8]  = '{1, 0,  5, 257, 1, 0,  200,  100,  0, 261, 195,  105};
    vecs[9]  = '{1, 0,  5, 258, 1, 0,  200,  100,  6, 258, 200,  100};
    vecs[10] = '{3, 2,  9,   2, 1, 0,  200,  100,  6, 258, 200,  100};
    vecs[11] = '{3, 1,  6,   3, 1, 0,    6,   10,  0,  7,    0,   16};
    vecs[12] = '{0, 2,  6,   4, 1, 0,   10, 4089,  0,  8,    4, 4095};
    vecs[13] = '{2, 0, 77,   5, 1, 4,  300,  123,  0,  9,  223,  200};

    // ---- reset ----
    resetn = 1'b0; start = 1'b0; sender = '0; receiver = '0;
    amount_in = '0; key_in = '0; verify_valid = 1'b0; verify_pass = 1'b0;
    tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    resetn = 1'b1;
    @(posedge clock); #1;

    // ---- table-driven vectors ----
    for (int i = 0; i < 14; i++) begin
      set_bal(vecs[i].s, vecs[i].bal_s);
      set_bal(vecs[i].r, vecs[i].bal_r);
      if (vecs[i].exp_st == 0) begin
        push_wr(vecs[i].s, vecs[i].exp_s);
        push_wr(vecs[i].r, vecs[i].exp_r);
      end
      xfer(vecs[i].s, vecs[i].r, vecs[i].amt, vecs[i].vc, vecs[i].pass != 0,
           vecs[i].pulses, vecs[i].exp_st, st, dc);
      check($sformatf("vec%0d_status", i), st, vecs[i].exp_st);
      check($sformatf("vec%0d_done_cycle", i), dc, vecs[i].exp_dc);
      check($sformatf("vec%0d_bal_s", i), int'(mem[vecs[i].s]), vecs[i].exp_s);
      check($sformatf("vec%0d_bal_r", i), int'(mem[vecs[i].r]), vecs[i].exp_r);
    end

    // ---- reset during VERIFY: no write, outputs back to reset values ----
    set_bal(0, 100); set_bal(1, 50);
    run_until(0, 1, 30, 3);
    check("rstv_in_verify", int'(state_dbg), 3);
    resetn = 1'b0;
    @(posedge clock); #1;
    check_reset_outputs("rstv");
    resetn = 1'b1;
    check("rstv_bal0", int'(mem[0]), 100);
    check("rstv_bal1", int'(mem[1]), 50);

    // ---- reset held low through WR_SEND: write enable suppressed ----
    run_until(0, 1, 30, 5);
    check("rstw_in_wr_send", int'(state_dbg), 5);
    resetn = 1'b0; #1;
    check("rstw_mem_we_low", int'(mem_we), 0);
    @(posedge clock); #1;
    resetn = 1'b1;
    check("rstw_busy", int'(busy), 0);
    check("rstw_bal0", int'(mem[0]), 100);
    check("rstw_bal1", int'(mem[1]), 50);

    // ---- reset in WR_RECV: debit lands, credit does not ----
    run_until(0, 1, 30, 6);
    check("rstr_in_wr_recv", int'(state_dbg), 6);
    resetn = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b1;
    check("rstr_bal0", int'(mem[0]), 70);
    check("rstr_bal1", int'(mem[1]), 50);

    // ---- nominal transfer after reset, then back-to-back early reject ----
    set_bal(0, 100); set_bal(1, 50);
    push_wr(0, 70); push_wr(1, 80);
    xfer(0, 1, 30, 3, 1'b1, 0, 0, st, dc);
    check("post_rst_status", st, 0);
    check("post_rst_done_cycle", dc, 7);
    xfer(3, 3, 1, 3, 1'b1, 0, 4, st, dc);
    check("b2b_status", st, 4);
    check("b2b_done_cycle", dc, 1);

    // ---- randomized transfers against the model ----
    for (int n = 0; n < 40; n++) begin
      s   = $urandom_range(0, 3);
      r   = ($urandom_range(0, 5) == 0) ? s : $urandom_range(0, 3);
      amt = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      set_bal(s, $urandom_range(0, 400));
      if (r != s) set_bal(r, ($urandom_range(0, 1) == 1) ? $urandom_range(3800, 4095)
                                                         : $urandom_range(0, 4095));
      vc   = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 2) : $urandom_range(3, 8);
      pass = ($urandom_range(0, 4) != 0);
      model_xfer(s, r, amt, vc, pass, est, edc);
      xfer(s, r, amt, vc, pass, $urandom_range(0, 3), est, st, dc);
      check("rnd_status", st, est);
      check("rnd_done_cycle", dc, edc);
      check("rnd_bal_s", int'(mem[s]), model_mem[s]);
      check("rnd_bal_r", int'(mem[r]), model_mem[r]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
